// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-port round-robin ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_NOT = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  // Latched operation payload fed to the shared ALU.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } alu_op_t;

  function automatic logic op_legal(input logic [SEL_W-1:0] sel);
    return (sel <= OP_NOT);
  endfunction

endpackage

// File: rtl/alu_sched_alu.sv
// Shared combinational 4-bit ALU datapath; illegal opcodes yield zero.
module alu_sched_alu
  import alu_sched_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (sel_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_NOT:  result_o = ~a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between two valid/ready requesters,
// holding each registered result until its owner consumes it.
module alu_sched
  import alu_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic             busy
);

  sched_state_t     state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  alu_op_t          op_q, op_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] alu_result;
  logic             grant0, grant1;
  logic             legal;
  logic [WIDTH-1:0] exec_data;
  logic             owner_rsp_ready;

  alu_sched_alu u_alu (
    .a_i      (op_q.a),
    .b_i      (op_q.b),
    .sel_i    (op_q.sel),
    .result_o (alu_result)
  );

  // Grant: lone requester wins, contention resolved by prio.
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid ||  prio_q);

  assign req0_ready = (state_q == IDLE) && !rst && grant0;
  assign req1_ready = (state_q == IDLE) && !rst && grant1;

  assign legal           = op_legal(op_q.sel);
  assign exec_data       = legal ? alu_result : '0;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          op_d    = '{a: req0_a, b: req0_b, sel: req0_sel};
          owner_d = 1'b0;
          prio_d  = 1'b1;
          state_d = EXEC;
        end else if (req1_ready) begin
          op_d    = '{a: req1_a, b: req1_b, sel: req1_sel};
          owner_d = 1'b1;
          prio_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) data1_d = exec_data;
        else         data0_d = exec_data;
        rsp_err_d[owner_q]   = !legal;
        rsp_valid_d[owner_q] = 1'b1;
        state_d              = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      op_q        <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_data  = data0_q;
  assign rsp1_data  = data1_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: vector table, random ops against a model,
// arbitration alternation, backpressure and mid-operation reset sequences.
module tb_alu_sched;
  import alu_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid, req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             rsp0_err, rsp1_err, busy;

  int tests = 0;
  int fails = 0;
  int tb_prio = 0;

  always #5 clk = ~clk;

  alu_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp0_err   (rsp0_err),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .rsp1_err   (rsp1_err),
    .busy       (busy)
  );

  typedef struct {
    int         port;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result from the opcode table, modulo 16.
  function automatic int model_data(input int a, input int b, input int sel);
    case (sel)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      3:       return a | b;
      4:       return 15 - a;
      default: return 0;
    endcase
  endfunction

  function automatic logic rdy(input int port);
    return (port == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic vld(input int port);
    return (port == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  function automatic logic [3:0] dat(input int port);
    return (port == 1) ? rsp1_data : rsp0_data;
  endfunction

  function automatic logic errf(input int port);
    return (port == 1) ? rsp1_err : rsp0_err;
  endfunction

  task automatic drive_req(input int port, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [2:0] sel);
    if (port == 1) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  task automatic set_rsp_ready(input int port, input logic v);
    if (port == 1) rsp1_ready = v;
    else           rsp0_ready = v;
  endtask

  // Returns one cycle before the handshake edge, with ready observed high.
  task automatic wait_grant(input int port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (rdy(port)) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic do_op(input string name, input int port, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] sel,
                       input logic [3:0] exp_d, input logic exp_e);
    bit ok;
    drive_req(port, 1'b1, a, b, sel);
    drive_req(1 - port, 1'b0, 4'h0, 4'h0, 3'h0);
    wait_grant(port, ok);
    if (!ok) begin
      check({name, "_grant_timeout"}, 32'd0, 32'd1);
      drive_req(port, 1'b0, a, b, sel);
      return;
    end
    tick();
    drive_req(port, 1'b0, a, b, sel);
    check({name, "_exec_valid"}, 32'(vld(port)), 32'd0);
    check({name, "_exec_busy"}, 32'(busy), 32'd1);
    tick();
    check({name, "_valid"}, 32'(vld(port)), 32'd1);
    check({name, "_data"}, 32'(dat(port)), 32'(exp_d));
    check({name, "_err"}, 32'(errf(port)), 32'(exp_e));
    check({name, "_other_valid"}, 32'(vld(1 - port)), 32'd0);
    set_rsp_ready(port, 1'b1);
    tick();
    set_rsp_ready(port, 1'b0);
    check({name, "_consumed"}, 32'(vld(port)), 32'd0);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    tb_prio = 1 - port;
  endtask

  initial begin
    bit ok;
    int gp;
    logic [3:0] ea [2];
    logic [3:0] eb [2];
    logic [2:0] es [2];

    rst = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    drive_req(0, 1'b1, 4'h6, 4'h3, OP_AND);
    drive_req(1, 1'b1, 4'h9, 4'h4, OP_OR);

    vecs[0] = '{0, 4'h3, 4'h4, 3'b000, 4'h7, 1'b0};
    vecs[1] = '{1, 4'h2, 4'h5, 3'b001, 4'hD, 1'b0};
    vecs[2] = '{0, 4'hF, 4'h1, 3'b000, 4'h0, 1'b0};
    vecs[3] = '{0, 4'h7, 4'h9, 3'b110, 4'h0, 1'b1};
    vecs[4] = '{0, 4'h5, 4'h3, 3'b010, 4'h1, 1'b0};
    vecs[5] = '{1, 4'h5, 4'hC, 3'b100, 4'hA, 1'b0};
    vecs[6] = '{1, 4'hE, 4'h1, 3'b111, 4'h0, 1'b1};
    vecs[7] = '{1, 4'h9, 4'h4, 3'b011, 4'hD, 1'b0};

    // Reset state, with both ports requesting.
    tick();
    tick();
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_data0", 32'(rsp0_data), 32'd0);
    check("rst_err0", 32'(rsp0_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Both valid at release: port 0 first, then backpressure, then port 1.
    rst = 1'b0;
    #1;
    check("rel_ready0", 32'(req0_ready), 32'd1);
    check("rel_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check("bp_exec_busy", 32'(busy), 32'd1);
    #1;
    check("bp_exec_ready1", 32'(req1_ready), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp0_valid), 32'd1);
      check("bp_data", 32'(rsp0_data), 32'h2);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_ready1", 32'(req1_ready), 32'd0);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check("bp_released", 32'(rsp0_valid), 32'd0);
    #1;
    check("bp_grant1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    check("p1_valid", 32'(rsp1_valid), 32'd1);
    check("p1_data", 32'(rsp1_data), 32'hD);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    check("p1_consumed", 32'(rsp1_valid), 32'd0);
    tb_prio = 0;

    // Directed vector table.
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b,
            vecs[i].sel, vecs[i].exp_data, vecs[i].exp_err);

    // Random single-port operations against the model.
    for (int i = 0; i < 30; i++) begin
      int p, a, b, s;
      p = int'($urandom_range(1));
      a = int'($urandom_range(15));
      b = int'($urandom_range(15));
      s = int'($urandom_range(7));
      do_op($sformatf("rnd%0d", i), p, 4'(a), 4'(b), 3'(s),
            4'(model_data(a, b, s)), s > 4);
    end

    // Sustained requests from both ports must alternate grants.
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      ea[p] = 4'($urandom_range(15));
      eb[p] = 4'($urandom_range(15));
      es[p] = 3'($urandom_range(4));
      drive_req(p, 1'b1, ea[p], eb[p], es[p]);
    end
    for (int g = 0; g < 8; g++) begin
      logic [3:0] xa, xb;
      logic [2:0] xs;
      ok = 1'b0;
      for (int w = 0; w < 10 && !ok; w++) begin
        #1;
        if (req0_ready || req1_ready) ok = 1'b1;
        else tick();
      end
      if (!ok) begin
        check("alt_timeout", 32'd0, 32'd1);
        break;
      end
      check("alt_single_grant", 32'(req0_ready && req1_ready), 32'd0);
      gp = req1_ready ? 1 : 0;
      check($sformatf("alt_order%0d", g), 32'(gp), 32'(tb_prio));
      xa = ea[gp]; xb = eb[gp]; xs = es[gp];
      tick();
      ea[gp] = 4'($urandom_range(15));
      eb[gp] = 4'($urandom_range(15));
      es[gp] = 3'($urandom_range(4));
      drive_req(gp, 1'b1, ea[gp], eb[gp], es[gp]);
      tick();
      check("alt_valid", 32'(vld(gp)), 32'd1);
      check("alt_data", 32'(dat(gp)), 32'(model_data(int'(xa), int'(xb), int'(xs))));
      tb_prio = 1 - gp;
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    tick();

    // Reset pulse during EXEC.
    drive_req(0, 1'b1, 4'h5, 4'h6, OP_ADD);
    wait_grant(0, ok);
    check("rexec_grant", 32'(ok), 32'd1);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rexec_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rexec_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rexec_data0", 32'(rsp0_data), 32'd0);
    check("rexec_data1", 32'(rsp1_data), 32'd0);
    check("rexec_busy", 32'(busy), 32'd0);
    tick();
    check("rexec_no_stale", 32'(rsp0_valid), 32'd0);
    drive_req(0, 1'b1, 4'h5, 4'h6, OP_ADD);
    drive_req(1, 1'b1, 4'h1, 4'h1, OP_ADD);
    #1;
    check("rexec_prio_ready0", 32'(req0_ready), 32'd1);
    check("rexec_prio_ready1", 32'(req1_ready), 32'd0);

    // Port 0 takes this grant; then reset pulse during RESP.
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("rresp_valid_before", 32'(rsp0_valid), 32'd1);
    check("rresp_data_before", 32'(rsp0_data), 32'hB);
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rresp_ready0_in_rst", 32'(req0_ready), 32'd0);
    check("rresp_ready1_in_rst", 32'(req1_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("rresp_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rresp_data0", 32'(rsp0_data), 32'd0);
    check("rresp_err0", 32'(rsp0_err), 32'd0);
    check("rresp_busy", 32'(busy), 32'd0);
    #1;
    check("rresp_prio_ready0", 32'(req0_ready), 32'd1);
    check("rresp_prio_ready1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("rresp_no_stale", 32'(rsp0_valid), 32'd0);
    check("rresp_idle_busy", 32'(busy), 32'd0);
    tb_prio = 0;

    // Error flag clears on the next legal op.
    do_op("err_set", 0, 4'h3, 4'h3, 3'b101, 4'h0, 1'b1);
    do_op("err_clear", 0, 4'h3, 4'h3, OP_OR, 4'h3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
